// File: rtl/rv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states, datapath mux selects.
// No logic; used by the control FSM and the testbench-visible debug state output.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_ALU   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // Opcodes that take the EX stage; anything else retires in ID as a NOP.
    function automatic logic is_exec_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I_ALU) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic uses_imm(input logic [6:0] op);
        return (op == OP_I_ALU) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_perf_counters.sv
// Cycle and retired-instruction counters, both wrapping modulo 2^CNT_W.
// Latency: counts visible the cycle after the counted edge. No backpressure.
module perf_counters
    import rv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (run) begin
            cycle_d = cycle_q + CNT_W'(1);
            if (retire) begin
                instret_d = instret_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM sequencing IF/ID/EX/MEM/WB with one pc_write per instruction.
// Latency: 3-5 cycles per instruction plus memory wait cycles; outputs are combinational from state/opcode.
// Backpressure: IF and MEM hold their request until the matching ready is sampled high.
module multicycle_control_fsm
    import rv_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int ST_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             ecall_halt,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_b,
    output logic             is_halted,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_write = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_PLUS4;
        reg_write  = 1'b0;
        wb_sel     = WB_SEL_ALU;
        alu_src_b  = 1'b0;
        case (state_q)
            ST_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_ID;
                end
            end
            ST_ID: begin
                if (opcode == OP_ECALL && ecall_halt) begin
                    state_d = ST_HALT;
                end else if (is_exec_op(opcode)) begin
                    state_d = ST_EX;
                end else begin
                    pc_write = 1'b1;
                    state_d  = ST_IF;
                end
            end
            ST_EX: begin
                alu_src_b = uses_imm(opcode);
                if (opcode == OP_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = bcond ? PC_SRC_IMM : PC_SRC_PLUS4;
                    state_d  = ST_IF;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req   = 1'b1;
                dmem_write = (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_write = 1'b1;
                        state_d  = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_IF;
                if (opcode == OP_LOAD) begin
                    wb_sel = WB_SEL_MEM;
                end else if (opcode == OP_JAL) begin
                    wb_sel = WB_SEL_PC4;
                    pc_src = PC_SRC_IMM;
                end else if (opcode == OP_JALR) begin
                    wb_sel = WB_SEL_PC4;
                    pc_src = PC_SRC_ALU;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IF;
        endcase
        // IF would otherwise request a fetch while the rest of the core is held in reset.
        if (!reset) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_write = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_b  = 1'b0;
        end
    end

    assign is_halted = (state_q == ST_HALT);
    assign state     = ST_W'(state_q);

    perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk           (clk),
        .reset         (reset),
        .run           (reset),
        .retire        (pc_write),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle successor to the single-cycle control unit: a state machine that sequences each RV32I instruction through IF/ID/EX/MEM/WB over several clocks, with ready/valid-style wait states for instruction and data memory of arbitrary latency. It sits between the instruction register (opcode source) and the shared datapath (PC, register file, ALU, memories). It drives per-cycle enables and mux selects, raises the halt flag, and keeps cycle and retired-instruction counters.

## Interface
Parameters:
- CNT_W, 32, width of cycle and instret counters
- ST_W, 3, state encoding width (fixed encodings in package)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- opcode  in  7  opcode field of the latched instruction register
- bcond  in  1  ALU branch-condition result, valid in EX
- ecall_halt  in  1  high when x17 == 10 (from register file), valid in ID
- imem_ready  in  1  instruction memory has data / completed
- dmem_ready  in  1  data memory access completed
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_write  out  1  data access is a store (qualifies dmem_req)
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC this cycle
- pc_src  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result (JALR)
- reg_write  out  1  register file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- alu_src_b  out  1  0 = rs2, 1 = immediate
- is_halted  out  1  sticky halt flag
- state  out  ST_W  current state (debug)
- cycle_count  out  CNT_W  cycles since reset release
- instret_count  out  CNT_W  retired instructions

## Operation
- States: IF, ID, EX, MEM, WB, HALT.
- IF: imem_req=1. Stay until imem_ready. On imem_ready: ir_write=1, go to ID.
- ID: decode opcode.
  - ECALL with ecall_halt → HALT.
  - ECALL without halt, or unknown opcode: retire as NOP (pc_write, pc_src=0) → IF.
  - All other opcodes → EX.
- EX: alu_src_b=1 for I-type ALU, LOAD, STORE, JALR; else 0.
  - BRANCH: pc_write=1, pc_src = bcond ? 1 : 0, retire → IF.
  - LOAD/STORE → MEM.
  - R, I-ALU, JAL, JALR → WB.
- MEM: dmem_req=1, dmem_write=1 for STORE. Stay until dmem_ready.
  - LOAD → WB.
  - STORE: pc_write=1, pc_src=0, retire → IF.
- WB: reg_write=1, pc_write=1.
  - R/I-ALU: wb_sel=0, pc_src=0.
  - LOAD: wb_sel=1, pc_src=0.
  - JAL: wb_sel=2, pc_src=1.
  - JALR: wb_sel=2, pc_src=2.
  - Retire → IF.
- HALT: absorbing. All enables 0, is_halted=1. Only reset exits.
- Retire cycle: the single cycle with pc_write=1 for an instruction. instret_count increments by 1 in that cycle. Exactly one pc_write per instruction.
- Counters wrap modulo 2^CNT_W. cycle_count increments every cycle out of reset, including HALT.

## Timing
- Outputs are combinational from state and opcode (Moore + opcode decode); state and counters are registered.
- Reset asserted: state=IF, is_halted=0, counters=0, immediately (asynchronous). While reset is low, all enables and requests are 0, including imem_req.
- Reset deasserted: first rising edge begins counting.
- Minimum cycles per instruction, with zero-wait memory (ready in the same cycle as req):
  - Branch: 3.
  - R/I/JAL/JALR: 4.
  - Store: 4.
  - Load: 5.
- Each memory wait cycle adds 1 cycle.
- Request/ready handshake:
  - Request stays high until the cycle ready is sampled high.
  - ready while req is low is ignored.
- Reset mid-instruction (e.g. during a MEM wait) aborts with no pc_write or reg_write. The FSM restarts in IF.

## Structure
- Shared package rv_pkg holds:
  - opcode constants (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, ECALL);
  - state enum (IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5);
  - pc_src and wb_sel encodings.
- Sub-module perf_counters (CNT_W) holds cycle_count and instret_count; its inputs are clk, reset, run (not in reset) and retire (pc_write).

## Test plan
- Reset: hold reset=0 for 3 cycles → state=IF, all enables 0, counters 0, is_halted=0.
- ADD with ready tied high → states IF,ID,EX,WB. reg_write and pc_write only in WB, wb_sel=0. instret=1 and cycle_count=4 after 4 cycles.
- LOAD with dmem_ready delayed 2 cycles → MEM held 3 cycles with dmem_req=1, dmem_write=0. Then WB with wb_sel=1. Total 7 cycles.
- BEQ with bcond=1, then BEQ with bcond=0 → EX retire with pc_src=1, then pc_src=0. Each takes 3 cycles; reg_write is never asserted.
- ECALL with ecall_halt=1 → HALT after ID. is_halted stays 1 and instret stays constant over 10 cycles while cycle_count keeps incrementing.
- STORE, reset pulled low during a MEM wait → no pc_write or reg_write occurs. After release, the FSM restarts at IF with counters 0.
